// File: rtl/cla_serial_sub.sv
// Serial WIDTH-bit subtractor: diff = a - b - borrow_in, one 4-bit CLA slice per cycle.
// Latency: accept edge 0, out_valid rises after edge NSLICE+1 (5 edges at WIDTH=16).
// Backpressure: in_ready only in IDLE; DONE holds result/flags until out_ready.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake (a, b, borrow_in)
//   out_valid/out_ready   result handshake (diff, borrow_out, ovf, zero)
module cla_serial_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IW     = $clog2(NSLICE + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, diff_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q, c3_q, borrow_q, ovf_q, zero_q;

  logic [3:0] p, g, s;
  logic       c1, c2, c3, c4;
  logic       slicing, last_slice;

  // Operands are shifted right one slice per RUN edge, so the active slice
  // is always in the low nibble.
  always_comb begin
    p  = a_sh[3:0] ^ ~b_sh[3:0];
    g  = a_sh[3:0] & ~b_sh[3:0];
    c1 = g[0] | (p[0] & carry_q);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & carry_q);
    s  = p ^ {c3, c2, c1, carry_q};
  end

  // idx == NSLICE is the finalize edge: all slices done, flags latched on entry to DONE.
  assign slicing    = (idx_q != IW'(NSLICE));
  assign last_slice = (idx_q == IW'(NSLICE - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (!slicing)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      diff_q   <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      c3_q     <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_sh    <= a;
          b_sh    <= b;
          carry_q <= ~borrow_in;  // subtract as a + ~b + ~borrow_in
          idx_q   <= '0;
          diff_q  <= '0;
        end
        RUN: if (slicing) begin
          a_sh    <= a_sh >> 4;
          b_sh    <= b_sh >> 4;
          // diff was cleared at accept, so OR-ing places the nibble at 4*idx.
          diff_q  <= diff_q | (WIDTH'(s) << {idx_q, 2'b00});
          carry_q <= c4;
          if (last_slice) c3_q <= c3;
          idx_q   <= idx_q + 1'b1;
        end else begin
          borrow_q <= ~carry_q;
          ovf_q    <= c3_q ^ carry_q;
          zero_q   <= (diff_q == '0);
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign ovf        = ovf_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_cla_serial_sub.sv
// Self-checking bench for cla_serial_sub (WIDTH=16): directed corner cases,
// backpressure and mid-operation reset, then random operations against an
// arithmetic reference model.
module tb_cla_serial_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] a, b;
  logic        borrow_in;
  logic        out_valid, out_ready;
  logic [15:0] diff;
  logic        borrow_out, ovf, zero;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cla_serial_sub #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .borrow_in(borrow_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow_out(borrow_out), .ovf(ovf), .zero(zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic.
  task automatic model(input logic [15:0] ai, input logic [15:0] bi, input bit bin,
                       output logic [15:0] d, output bit bo, output bit ov, output bit z);
    int u, sg;
    u  = int'(ai) - int'(bi) - int'(bin);
    sg = int'($signed(ai)) - int'($signed(bi)) - int'(bin);
    d  = u[15:0];
    bo = (u < 0);
    ov = (sg > 32767) || (sg < -32768);
    z  = (d == 16'h0);
  endtask

  // Called at a negedge with the DUT in IDLE.
  task automatic do_op(input logic [15:0] ai, input logic [15:0] bi, input bit bin,
                       input int hold);
    logic [15:0] ed, held;
    bit eb, eo, ez;
    int lat;
    model(ai, bi, bin, ed, eb, eo, ez);
    chk("in_ready_idle", in_ready, 1);
    a = ai; b = bi; borrow_in = bin; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); borrow_in = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      a = 16'($urandom); b = 16'($urandom);
    end
    chk("latency", lat, 5);
    chk("in_ready_done", in_ready, 0);
    chk("diff", diff, ed);
    chk("borrow_out", borrow_out, eb);
    chk("ovf", ovf, eo);
    chk("zero", zero, ez);
    held = diff;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;  // must be ignored outside IDLE
      a = 16'($urandom); b = 16'($urandom);
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_diff", diff, held);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_stale_diff", diff, ed);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; borrow_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow_out, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_zero", zero, 0);

    do_op(16'h1234, 16'h0235, 1'b0, 0);
    do_op(16'h0000, 16'h0001, 1'b0, 0);
    do_op(16'h8000, 16'h0001, 1'b0, 0);
    do_op(16'h7FFF, 16'hFFFF, 1'b0, 0);
    do_op(16'h0005, 16'h0003, 1'b1, 0);
    do_op(16'hABCD, 16'hABCD, 1'b0, 0);
    do_op(16'h0000, 16'hFFFF, 1'b1, 0);
    do_op(16'hC3A5, 16'h5A3C, 1'b1, 10);

    // Reset while the third slice is pending.
    a = 16'hFFFF; b = 16'h0001; borrow_in = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_diff", diff, 0);
    @(negedge clk);
    chk("abort_stays_idle", out_valid, 0);
    do_op(16'h4321, 16'h1234, 1'b1, 0);

    for (int k = 0; k < 200; k++)
      do_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
